ras_ckpt_queue: RTL
===================

# ras_ckpt_queue

RAS checkpoint queue: the other end of the `ras` recovery interface. It captures the `ras` stack pointer, plus the call/return kind, for every in-flight control-flow instruction at fetch, and retires the entry in order at commit. On a branch mispredict it drives `recover`/`recover_ptr` back into `ras` and discards all younger checkpoints. It sits in the front end beside the RAS and FTQ.

## Interface
- `DEPTH`, 8: checkpoint entries; power of two, ≥2.
- `RAS_DEPTH`, 16: depth of the attached `ras`.
- `RAS_PTR_W`, `$clog2(RAS_DEPTH)+1`: width of the RAS pointer.
- `TAG_W`, `$clog2(DEPTH)`: width of an entry index.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `alloc_valid` in 1: allocate a checkpoint this cycle.
- `alloc_ras_ptr` in `RAS_PTR_W`: `ras.ptr` value before this instruction's push/pop.
- `alloc_kind` in 2: `ras_kind_e`; NONE=0, CALL=1, RET=2.
- `alloc_rdy` out 1: queue not full and no mispredict this cycle.
- `alloc_tag` out `TAG_W`: index assigned to the current allocation, equal to the tail index.
- `commit_valid` in 1: free the oldest entry.
- `commit_rdy` out 1: queue not empty.
- `mispredict` in 1: mispredict strobe.
- `mispredict_tag` in `TAG_W`: tag of the mispredicted instruction.
- `recover` out 1: pulse to `ras.recover`.
- `recover_ptr` out `RAS_PTR_W`: drives `ras.recover_ptr`.
- `count` out `TAG_W+1`: current occupancy.

## Operation
- Circular buffer with `head` and `tail`, each `TAG_W+1` bits including a wrap bit.
  - Empty: `head==tail`.
  - Full: indices equal and wrap bits differ.
- Each entry holds `{ras_ptr, kind}`.
- Alloc fires on `alloc_valid && alloc_rdy`: it writes `entry[tail]` and then increments `tail`.
- Commit fires on `commit_valid && commit_rdy`: it increments `head`. `commit_valid` while empty is ignored.
- A mispredict tag is live when it lies in `[head, tail)`, using modular comparison on the wrap-extended pointers. On a live mispredict:
  - `tail` is set to `tag+1`, re-extended with the correct wrap bit. The mispredicted instruction's own entry is kept.
  - `recover_ptr` is computed from `entry[tag]`:
    - CALL: `min(ptr+1, RAS_DEPTH)`.
    - RET: `max(ptr-1, 0)`.
    - NONE: `ptr` unchanged.
  - `recover` pulses for exactly one cycle.
- A mispredict on a non-live tag (stale or empty) is ignored: no recover and no pointer change.
- Simultaneous events:
  - mispredict + alloc: the alloc is blocked, because `alloc_rdy` is low combinationally.
  - mispredict + commit: the commit is applied, and liveness is evaluated against the pre-commit `head`. If the committing entry is the mispredicted tag, the recover still fires and the queue ends empty.
  - alloc + commit, not full: both fire and `count` is unchanged.
  - Full: `alloc_rdy=0` until a commit occurs. A same-cycle commit does not raise `alloc_rdy`, so there is no combinational path from commit to `alloc_rdy`.
- `count = tail - head`, computed modulo `2*DEPTH`. It reads `DEPTH` when full.

## Timing
- Reset values: `head=tail=0`, `count=0`, `alloc_rdy=1`, `commit_rdy=0`, `alloc_tag=0`, `recover=0`, `recover_ptr=0`. Entry contents are don't-care and are not reset.
- Alloc and commit take effect at the next rising edge. A value allocated at edge N can be committed at edge N+1.
- `recover`/`recover_ptr` are registered: they are valid in the cycle after the mispredict edge, with 1-cycle latency. `recover_ptr` holds its value when `recover=0`.
- `tail` is truncated at the same edge that registers `recover`. `alloc_rdy` reflects the truncated state in the following cycle.
- A reset asserted mid-operation overrides everything: `recover` is forced to 0 in the next cycle, even if a mispredict is pending.
- Back-to-back mispredicts are each evaluated against the state left by the previous one.

## Configuration
- `RAS_CKPT_FAST_RECOVER_EN` defined:
  - `recover` and `recover_ptr` are combinational from `mispredict` and `entry[mispredict_tag]` in the same cycle.
  - `recover_ptr` reads 0 when `recover=0`.
  - `tail` update timing is unchanged.
- `RAS_CKPT_FAST_RECOVER_EN` undefined: registered outputs as described in Timing.

## Structure
- The `uarch_pkg` package holds:
  - the `ras_kind_e` enum (NONE/CALL/RET);
  - the `ras_ckpt_t` struct `{ras_ptr, kind}`;
  - the constants `RAS_DEPTH` and `RAS_CKPT_DEPTH`.
- One sub-module, `ras_ptr_adjust`: combinational saturating ±1 on the pointer by kind. The same logic is reused by the predecode path.
- Storage is a flop array. No SRAM.

## Test plan
- Reset, then alloc ptr=0/NONE, ptr=1/CALL, ptr=2/RET → `alloc_tag` values 0, 1, 2; `count=3`; `commit_rdy=1`.
- Fill 8 entries → `alloc_rdy=0`. Alloc+commit in the same cycle → commit only, `count=7`. The next cycle alloc succeeds with `alloc_tag=0` (wrap).
- Alloc tags 0..4, tag 2 = `{ptr=5, CALL}`. Mispredict tag 2 → next cycle `recover=1`, `recover_ptr=6`, `count=3`, next `alloc_tag=3`.
- RET entry with ptr=0 → `recover_ptr=0` (saturation). CALL entry with ptr=16 → `recover_ptr=16`.
- Mispredict on a committed or never-allocated tag, or while empty → `recover` stays 0 and `count` is unchanged.
- Mispredict the head tag in the same cycle as its commit → `recover=1` with that entry's adjusted ptr, and `count=0`. Assert `rst` in the following cycle → all outputs return to their reset values.

Source files
------------

// File: rtl/uarch_pkg.sv
// Shared front-end types: RAS push/pop kind and the checkpoint record kept per
// in-flight control-flow instruction.
package uarch_pkg;

   localparam int RAS_DEPTH      = 16;
   localparam int RAS_CKPT_DEPTH = 8;
   localparam int RAS_PTR_W      = $clog2(RAS_DEPTH) + 1;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      CALL = 2'd1,
      RET  = 2'd2
   } ras_kind_e;

   typedef struct packed {
      logic [RAS_PTR_W-1:0] ras_ptr;
      ras_kind_e            kind;
   } ras_ckpt_t;

endpackage

// File: rtl/ras_ptr_adjust.sv
// Saturating +1 (CALL) / -1 (RET) on a RAS stack pointer; pass-through otherwise.
// Shared with the predecode path.
module ras_ptr_adjust #(
   parameter int RAS_DEPTH = uarch_pkg::RAS_DEPTH,
   parameter int PTR_W     = $clog2(RAS_DEPTH) + 1
) (
   input  logic                 [PTR_W-1:0] ptr,
   input  uarch_pkg::ras_kind_e             kind,
   output logic                 [PTR_W-1:0] ptr_adj
);
   import uarch_pkg::*;

   localparam logic [PTR_W-1:0] MAX_PTR = PTR_W'(RAS_DEPTH);
   localparam logic [PTR_W-1:0] ONE     = PTR_W'(1);

   always_comb begin
      ptr_adj = ptr;
      case (kind)
         CALL:    ptr_adj = (ptr < MAX_PTR) ? ptr + ONE : MAX_PTR;
         RET:     ptr_adj = (ptr != '0) ? ptr - ONE : '0;
         default: ptr_adj = ptr;
      endcase
   end

endmodule

// File: rtl/ras_ckpt_queue.sv
// In-order checkpoint queue of RAS pointers; drives recover/recover_ptr into the
// RAS on a mispredict. RAS_CKPT_FAST_RECOVER_EN makes the recover outputs combinational.
module ras_ckpt_queue #(
   parameter int DEPTH     = uarch_pkg::RAS_CKPT_DEPTH,
   parameter int RAS_DEPTH = uarch_pkg::RAS_DEPTH,
   parameter int RAS_PTR_W = $clog2(RAS_DEPTH) + 1,
   parameter int TAG_W     = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 alloc_valid,
   input  logic [RAS_PTR_W-1:0] alloc_ras_ptr,
   input  logic [1:0]           alloc_kind,
   output logic                 alloc_rdy,
   output logic [TAG_W-1:0]     alloc_tag,
   input  logic                 commit_valid,
   output logic                 commit_rdy,
   input  logic                 mispredict,
   input  logic [TAG_W-1:0]     mispredict_tag,
   output logic                 recover,
   output logic [RAS_PTR_W-1:0] recover_ptr,
   output logic [TAG_W:0]       count
);
   import uarch_pkg::*;

   localparam logic [TAG_W:0] ONE = (TAG_W+1)'(1);

   logic [TAG_W:0]       head_q, tail_q;
   ras_ckpt_t            ent_q [DEPTH];
   logic                 full, empty, alloc_fire, commit_fire, mp_live;
   logic [TAG_W-1:0]     mp_off;
   logic [RAS_PTR_W-1:0] mp_ptr_adj;

   assign count       = tail_q - head_q;
   assign empty       = (head_q == tail_q);
   assign full        = (head_q[TAG_W-1:0] == tail_q[TAG_W-1:0]) && (head_q[TAG_W] != tail_q[TAG_W]);
   assign alloc_rdy   = !full && !mispredict;
   assign commit_rdy  = !empty;
   assign alloc_tag   = tail_q[TAG_W-1:0];
   assign alloc_fire  = alloc_valid && alloc_rdy;
   assign commit_fire = commit_valid && commit_rdy;

   // Distance from head in index space; live iff it falls inside current occupancy.
   assign mp_off  = mispredict_tag - head_q[TAG_W-1:0];
   assign mp_live = mispredict && !rst && ({1'b0, mp_off} < count);

   ras_ptr_adjust #(
      .RAS_DEPTH (RAS_DEPTH),
      .PTR_W     (RAS_PTR_W)
   ) u_ptr_adjust (
      .ptr     (ent_q[mispredict_tag].ras_ptr),
      .kind    (ent_q[mispredict_tag].kind),
      .ptr_adj (mp_ptr_adj)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         head_q <= head_q + {{TAG_W{1'b0}}, commit_fire};
         if (mp_live)
            tail_q <= head_q + {1'b0, mp_off} + ONE;
         else
            tail_q <= tail_q + {{TAG_W{1'b0}}, alloc_fire};
      end
   end

   always_ff @(posedge clk) begin
      if (alloc_fire)
         ent_q[tail_q[TAG_W-1:0]] <= '{ras_ptr: alloc_ras_ptr, kind: ras_kind_e'(alloc_kind)};
   end

`ifdef RAS_CKPT_FAST_RECOVER_EN
   assign recover     = mp_live;
   assign recover_ptr = mp_live ? mp_ptr_adj : '0;
`else
   logic                 recover_q;
   logic [RAS_PTR_W-1:0] recover_ptr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         recover_q     <= 1'b0;
         recover_ptr_q <= '0;
      end else begin
         recover_q <= mp_live;
         if (mp_live)
            recover_ptr_q <= mp_ptr_adj;
      end
   end

   assign recover     = recover_q;
   assign recover_ptr = recover_ptr_q;
`endif

endmodule
